rocc_unit: RTL and testbench

ROCC_UNIT -- requirements
Module: rocc_unit

---
 rtl/rocc_unit.sv | 128 ++++++++++++
 tb/tb_rocc_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rocc_unit.sv
// RoCC issue unit: forwards one custom instruction at a time to an attached
// accelerator and writes its response back to the scoreboard.
module rocc_unit #(
  parameter int unsigned TRANS_ID_BITS = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     rocc_valid_i,
  output logic                     rocc_ready_o,
  input  logic [31:0]              rocc_instr_i,
  input  logic [63:0]              operand_a_i,
  input  logic [63:0]              operand_b_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  output logic                     cmd_valid_o,
  input  logic                     cmd_ready_i,
  output logic [31:0]              cmd_instr_o,
  output logic [63:0]              cmd_rs1_o,
  output logic [63:0]              cmd_rs2_o,
  input  logic                     resp_valid_i,
  output logic                     resp_ready_o,
  input  logic [63:0]              resp_data_i,
  input  logic [4:0]               resp_rd_i,
  output logic                     wb_valid_o,
  output logic [63:0]              wb_result_o,
  output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic                     busy_o
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CMD   = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] WB    = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;

  logic [2:0]               state_q, state_d;
  logic [31:0]              instr_q, instr_d;
  logic [63:0]              rs1_q, rs1_d;
  logic [63:0]              rs2_q, rs2_d;
  logic [TRANS_ID_BITS-1:0] tid_q, tid_d;
  logic                     xd_q, xd_d;
  logic [63:0]              result_q, result_d;

  // Response rd is informational only.
  logic unused_resp_rd;
  assign unused_resp_rd = ^resp_rd_i;

  assign rocc_ready_o  = (state_q == IDLE) && !flush_i;
  assign cmd_valid_o   = (state_q == CMD);
  assign resp_ready_o  = (state_q == WAIT) || (state_q == DRAIN);
  assign wb_valid_o    = (state_q == WB) && !flush_i;
  assign busy_o        = (state_q != IDLE);
  assign cmd_instr_o   = instr_q;
  assign cmd_rs1_o     = rs1_q;
  assign cmd_rs2_o     = rs2_q;
  assign wb_result_o   = result_q;
  assign wb_trans_id_o = tid_q;

  // Next-state and payload capture.
  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    tid_d    = tid_q;
    xd_d     = xd_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (rocc_valid_i && rocc_ready_o) begin
          instr_d = rocc_instr_i;
          rs1_d   = operand_a_i;
          rs2_d   = operand_b_i;
          tid_d   = trans_id_i;
          xd_d    = rocc_instr_i[14];
          state_d = CMD;
        end
      end
      CMD: begin
        if (cmd_ready_i) begin
          if (flush_i) begin
            state_d = xd_q ? DRAIN : IDLE;
          end else if (xd_q) begin
            state_d = WAIT;
          end else begin
            result_d = 64'd0;
            state_d  = WB;
          end
        end else if (flush_i) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        // A flushed instruction must still swallow its outstanding response.
        if (flush_i) begin
          state_d = resp_valid_i ? IDLE : DRAIN;
        end else if (resp_valid_i) begin
          result_d = resp_data_i;
          state_d  = WB;
        end
      end
      WB:    state_d = IDLE;
      DRAIN: if (resp_valid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      instr_q  <= 32'd0;
      rs1_q    <= 64'd0;
      rs2_q    <= 64'd0;
      tid_q    <= TRANS_ID_BITS'(0);
      xd_q     <= 1'b0;
      result_q <= 64'd0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      tid_q    <= tid_d;
      xd_q     <= xd_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_rocc_unit.sv
// Directed self-checking bench for rocc_unit.
module tb_rocc_unit;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        rocc_valid;
  logic        rocc_ready;
  logic [31:0] rocc_instr;
  logic [63:0] op_a, op_b;
  logic [2:0]  trans_id;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_instr;
  logic [63:0] cmd_rs1, cmd_rs2;
  logic        resp_valid, resp_ready;
  logic [63:0] resp_data;
  logic [4:0]  resp_rd;
  logic        wb_valid;
  logic [63:0] wb_result;
  logic [2:0]  wb_trans_id;
  logic        busy;

  int checks = 0;
  int errors = 0;

  rocc_unit #(.TRANS_ID_BITS(3)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .rocc_valid_i(rocc_valid), .rocc_ready_o(rocc_ready), .rocc_instr_i(rocc_instr),
    .operand_a_i(op_a), .operand_b_i(op_b), .trans_id_i(trans_id),
    .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready), .cmd_instr_o(cmd_instr),
    .cmd_rs1_o(cmd_rs1), .cmd_rs2_o(cmd_rs2),
    .resp_valid_i(resp_valid), .resp_ready_o(resp_ready), .resp_data_i(resp_data),
    .resp_rd_i(resp_rd),
    .wb_valid_o(wb_valid), .wb_result_o(wb_result), .wb_trans_id_o(wb_trans_id),
    .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    flush = 0; rocc_valid = 0; rocc_instr = 0; op_a = 0; op_b = 0; trans_id = 0;
    cmd_ready = 0; resp_valid = 0; resp_data = 0; resp_rd = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    cyc(); cyc();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b exp 0", busy); end
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL rst_cmd_valid got %0b exp 0", cmd_valid); end
    checks++; if (resp_ready !== 1'b0) begin errors++; $display("FAIL rst_resp_ready got %0b exp 0", resp_ready); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wb_valid got %0b exp 0", wb_valid); end
    checks++; if (wb_result !== 64'd0) begin errors++; $display("FAIL rst_wb_result got %h exp 0", wb_result); end
    checks++; if (cmd_rs1 !== 64'd0 || cmd_instr !== 32'd0) begin errors++; $display("FAIL rst_cmd_payload got %h/%h exp 0", cmd_instr, cmd_rs1); end
    rst = 0;
    cyc();
    checks++; if (rocc_ready !== 1'b1) begin errors++; $display("FAIL rst_rocc_ready got %0b exp 1", rocc_ready); end
  endtask

  task automatic test_xd1();
    rocc_valid = 1; rocc_instr = 32'h0000_600B; op_a = 64'h11; op_b = 64'h22; trans_id = 3'd5;
    #1;
    checks++; if (rocc_ready !== 1'b1) begin errors++; $display("FAIL xd1_ready got %0b exp 1", rocc_ready); end
    cyc();  // t+1
    clear_inputs(); cmd_ready = 1; #1;
    checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL xd1_cmd_valid got %0b exp 1", cmd_valid); end
    checks++; if (cmd_rs1 !== 64'h11 || cmd_rs2 !== 64'h22) begin errors++; $display("FAIL xd1_operands got %h/%h exp 11/22", cmd_rs1, cmd_rs2); end
    checks++; if (cmd_instr !== 32'h0000_600B) begin errors++; $display("FAIL xd1_instr got %h exp 0000600b", cmd_instr); end
    cyc();  // t+2 WAIT
    cmd_ready = 0; resp_valid = 1; resp_data = 64'hDEAD; #1;
    checks++; if (resp_ready !== 1'b1 || cmd_valid !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL xd1_wait got rr=%0b cv=%0b wv=%0b exp 1/0/0", resp_ready, cmd_valid, wb_valid); end
    cyc();  // t+3 WB
    resp_valid = 0; resp_data = 0; #1;
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL xd1_wb_valid got %0b exp 1", wb_valid); end
    checks++; if (wb_result !== 64'hDEAD || wb_trans_id !== 3'd5) begin errors++; $display("FAIL xd1_wb_payload got %h id %0d exp dead id 5", wb_result, wb_trans_id); end
    cyc();
    checks++; if (wb_valid !== 1'b0 || busy !== 1'b0 || rocc_ready !== 1'b1) begin errors++; $display("FAIL xd1_done got wv=%0b busy=%0b rdy=%0b exp 0/0/1", wb_valid, busy, rocc_ready); end
  endtask

  task automatic test_xd0_stall();
    int wb_pulses;
    wb_pulses = 0;
    rocc_valid = 1; rocc_instr = 32'h0000_200B; op_a = 64'hA5A5; op_b = 64'h5A5A; trans_id = 3'd2;
    cyc();
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      cmd_ready = (i == 3); #1;
      checks++; if (cmd_valid !== 1'b1 || cmd_rs1 !== 64'hA5A5 || cmd_rs2 !== 64'h5A5A || cmd_instr !== 32'h0000_200B)
        begin errors++; $display("FAIL xd0_cmd_stable[%0d] got v=%0b %h %h %h", i, cmd_valid, cmd_instr, cmd_rs1, cmd_rs2); end
      if (wb_valid) wb_pulses++;
      cyc();
    end
    cmd_ready = 0; #1;
    checks++; if (wb_valid !== 1'b1 || wb_result !== 64'd0 || wb_trans_id !== 3'd2) begin errors++; $display("FAIL xd0_wb got v=%0b %h id %0d exp 1 0 id 2", wb_valid, wb_result, wb_trans_id); end
    if (wb_valid) wb_pulses++;
    cyc();
    checks++; if (rocc_ready !== 1'b1) begin errors++; $display("FAIL xd0_ready_back got %0b exp 1", rocc_ready); end
    if (wb_valid) wb_pulses++;
    checks++; if (wb_pulses != 1) begin errors++; $display("FAIL xd0_wb_pulses got %0d exp 1", wb_pulses); end
  endtask

  task automatic test_flush_wait();
    rocc_valid = 1; rocc_instr = 32'h0000_600B; trans_id = 3'd1;
    cyc();
    clear_inputs(); cmd_ready = 1;
    cyc();  // WAIT
    cmd_ready = 0; flush = 1;
    cyc();  // DRAIN
    flush = 0;
    for (int i = 0; i < 4; i++) begin
      rocc_valid = 1;
      resp_valid = (i == 3); resp_data = 64'hBEEF; #1;
      checks++; if (rocc_ready !== 1'b0 || busy !== 1'b1 || resp_ready !== 1'b1 || wb_valid !== 1'b0)
        begin errors++; $display("FAIL drain[%0d] got rdy=%0b busy=%0b rr=%0b wv=%0b exp 0/1/1/0", i, rocc_ready, busy, resp_ready, wb_valid); end
      cyc();
    end
    clear_inputs(); #1;
    checks++; if (busy !== 1'b0 || rocc_ready !== 1'b1 || wb_valid !== 1'b0) begin errors++; $display("FAIL drain_exit got busy=%0b rdy=%0b wv=%0b exp 0/1/0", busy, rocc_ready, wb_valid); end
    cyc();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL drain_no_wb got %0b exp 0", wb_valid); end
  endtask

  task automatic test_flush_cmd();
    rocc_valid = 1; rocc_instr = 32'h0000_600B; trans_id = 3'd3;
    cyc();
    clear_inputs(); cmd_ready = 1; flush = 1;
    cyc();
    clear_inputs(); #1;
    checks++; if (busy !== 1'b1 || resp_ready !== 1'b1 || cmd_valid !== 1'b0) begin errors++; $display("FAIL flush_ready_drain got busy=%0b rr=%0b cv=%0b exp 1/1/0", busy, resp_ready, cmd_valid); end
    resp_valid = 1;
    cyc();
    clear_inputs(); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_ready_exit got busy=%0b exp 0", busy); end
    rocc_valid = 1; rocc_instr = 32'h0000_600B;
    cyc();
    clear_inputs(); flush = 1; #1;
    checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL flush_cmd_pre got %0b exp 1", cmd_valid); end
    cyc();
    flush = 0; #1;
    checks++; if (cmd_valid !== 1'b0 || busy !== 1'b0 || rocc_ready !== 1'b1) begin errors++; $display("FAIL flush_cmd_idle got cv=%0b busy=%0b rdy=%0b exp 0/0/1", cmd_valid, busy, rocc_ready); end
  endtask

  task automatic test_flush_idle_wb();
    rocc_valid = 1; flush = 1; rocc_instr = 32'h0000_200B; #1;
    checks++; if (rocc_ready !== 1'b0) begin errors++; $display("FAIL flush_idle_ready got %0b exp 0", rocc_ready); end
    cyc();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle_state got busy=%0b exp 0", busy); end
    flush = 0;
    cyc();  // CMD
    clear_inputs(); cmd_ready = 1;
    cyc();  // WB
    cmd_ready = 0; flush = 1; #1;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL flush_wb_gate got %0b exp 0", wb_valid); end
    cyc();
    flush = 0; #1;
    checks++; if (busy !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL flush_wb_exit got busy=%0b wv=%0b exp 0/0", busy, wb_valid); end
  endtask

  task automatic test_reset_wait();
    rocc_valid = 1; rocc_instr = 32'h0000_600B; op_a = 64'h77; trans_id = 3'd6;
    cyc();
    clear_inputs(); cmd_ready = 1;
    cyc();  // WAIT
    cmd_ready = 0; rst = 1;
    cyc();
    rst = 0; #1;
    checks++; if (busy !== 1'b0 || cmd_valid !== 1'b0 || resp_ready !== 1'b0 || wb_valid !== 1'b0)
      begin errors++; $display("FAIL rst_wait_ctrl got busy=%0b cv=%0b rr=%0b wv=%0b exp 0", busy, cmd_valid, resp_ready, wb_valid); end
    checks++; if (cmd_rs1 !== 64'd0 || wb_result !== 64'd0 || wb_trans_id !== 3'd0 || cmd_instr !== 32'd0)
      begin errors++; $display("FAIL rst_wait_payload got %h %h %h %0d exp 0", cmd_instr, cmd_rs1, wb_result, wb_trans_id); end
    checks++; if (rocc_ready !== 1'b1) begin errors++; $display("FAIL rst_wait_ready got %0b exp 1", rocc_ready); end
    resp_valid = 1; resp_data = 64'h1234;
    cyc();
    clear_inputs(); #1;
    checks++; if (wb_valid !== 1'b0 || busy !== 1'b0 || wb_result !== 64'd0) begin errors++; $display("FAIL late_resp got wv=%0b busy=%0b res=%h exp 0/0/0", wb_valid, busy, wb_result); end
  endtask

  task automatic test_back_to_back();
    int accepts, wbs;
    accepts = 0; wbs = 0;
    rocc_valid = 1; rocc_instr = 32'h0000_200B; cmd_ready = 1;
    for (int i = 0; i < 12; i++) begin
      trans_id = 3'(accepts);
      #1;
      checks++; if (busy && rocc_ready) begin errors++; $display("FAIL b2b_accept_busy[%0d] got rdy=%0b busy=%0b exp rdy 0", i, rocc_ready, busy); end
      if (rocc_valid && rocc_ready) accepts++;
      if (wb_valid) wbs++;
      cyc();
    end
    clear_inputs();
    checks++; if (accepts != 4) begin errors++; $display("FAIL b2b_accepts got %0d exp 4", accepts); end
    checks++; if (wbs != 4) begin errors++; $display("FAIL b2b_writebacks got %0d exp 4", wbs); end
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_xd1();
    test_xd0_stall();
    test_flush_wait();
    test_flush_cmd();
    test_flush_idle_wb();
    test_reset_wait();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
